// File: rtl/mdc_pkg.sv
// Shared definitions for the MDC clock generator: FSM encoding, default
// build constants and the divisor clamp helper.
package mdc_pkg;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } mdc_state_e;

    localparam int MDC_DIV_W       = 8;
    localparam int MDC_DIV_DEFAULT = 50;
    localparam int MDC_RST_STAGES  = 3;

    // A half-period of zero would stall the counter, so it behaves as one.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        logic [31:0] res;
        if (div == 32'd0) begin
            res = 32'd1;
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdc_clk_gen_if.sv
// Management clock control/status bundle between the MDIO controller
// (master) and the MDC clock generator (slave).
interface mdc_clk_gen_if
    import mdc_pkg::*;
#(
    parameter int DIV_W = MDC_DIV_W
);
    logic             Run;
    logic [DIV_W-1:0] Div_Half;
    logic             Div_Load;
    logic             MDC_Clk;
    logic             MDC_Rise;
    logic             MDC_Fall;
    logic             MDC_Rst;
    logic             Div_Pend;

    modport master (
        output Run, Div_Half, Div_Load,
        input  MDC_Clk, MDC_Rise, MDC_Fall, MDC_Rst, Div_Pend
    );

    modport slave (
        input  Run, Div_Half, Div_Load,
        output MDC_Clk, MDC_Rise, MDC_Fall, MDC_Rst, Div_Pend
    );
endinterface

// File: rtl/mdc_rst_sync.sv
// Asynchronous-assert / synchronous-deassert reset chain; the output drops
// on the STAGES-th Clk rising edge after Rst is released.
module mdc_rst_sync #(
    parameter int STAGES = 3
) (
    input  logic Clk,
    input  logic Rst,
    output logic Rst_Out
);
    logic [STAGES-1:0] sync_r;

    // Shift zeros in once Rst is released; any Rst reloads all ones.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_r <= {STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], 1'b0};
        end
    end

    assign Rst_Out = sync_r[STAGES-1];
endmodule

// File: rtl/mdc_clk_gen.sv
// MDC clock and management reset generator. Define MDC_DIV_RUNTIME_EN to
// enable runtime divisor loading through Div_Half/Div_Load.
module mdc_clk_gen
    import mdc_pkg::*;
#(
    parameter int DIV_W       = MDC_DIV_W,
    parameter int DIV_DEFAULT = MDC_DIV_DEFAULT,
    parameter int RST_STAGES  = MDC_RST_STAGES
) (
    input  logic          Clk,
    input  logic          Rst,
    mdc_clk_gen_if.slave  mdc
);
    mdc_state_e       state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] n_s;
    logic             last_s;
    logic             mdc_rst_s;
    logic             mdc_clk_r;
    logic             mdc_rise_r;
    logic             mdc_fall_r;

    mdc_rst_sync #(
        .STAGES (RST_STAGES)
    ) u_rst_sync (
        .Clk     (Clk),
        .Rst     (Rst),
        .Rst_Out (mdc_rst_s)
    );

`ifdef MDC_DIV_RUNTIME_EN
    logic [DIV_W-1:0] div_act_r;
    logic [DIV_W-1:0] div_pend_r;
    logic             pend_r;
    logic             boundary_s;

    assign n_s = DIV_W'(clamp_div(32'(div_act_r)));

    // Boundaries where a pending divisor may take effect: end of LOW, or leaving HIGH for PARK.
    always_comb begin
        boundary_s = 1'b0;
        case (state_r)
            ST_HIGH: begin
                if (!mdc.Run || mdc_rst_s) begin
                    boundary_s = 1'b1;
                end else begin
                    boundary_s = 1'b0;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    boundary_s = 1'b1;
                end else begin
                    boundary_s = 1'b0;
                end
            end
            default: boundary_s = 1'b0;
        endcase
    end

    // Pending/active divisor pair; a load coinciding with a boundary waits for the next one.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_act_r  <= DIV_W'(DIV_DEFAULT);
            div_pend_r <= {DIV_W{1'b0}};
            pend_r     <= 1'b0;
        end else begin
            if (boundary_s && pend_r) begin
                div_act_r <= div_pend_r;
            end else begin
                div_act_r <= div_act_r;
            end
            if (mdc.Div_Load) begin
                div_pend_r <= mdc.Div_Half;
                pend_r     <= 1'b1;
            end else if (boundary_s) begin
                pend_r     <= 1'b0;
            end else begin
                pend_r     <= pend_r;
            end
        end
    end

    assign mdc.Div_Pend = pend_r;
`else
    assign n_s          = DIV_W'(clamp_div(32'(DIV_DEFAULT)));
    assign mdc.Div_Pend = 1'b0;
`endif

    assign last_s = (cnt_r == (n_s - DIV_W'(1)));

    // Main FSM; MDC level and strobes are registered so they change together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_PARK;
            cnt_r      <= {DIV_W{1'b0}};
            mdc_clk_r  <= 1'b1;
            mdc_rise_r <= 1'b0;
            mdc_fall_r <= 1'b0;
        end else begin
            mdc_rise_r <= 1'b0;
            mdc_fall_r <= 1'b0;
            case (state_r)
                ST_PARK: begin
                    mdc_clk_r <= 1'b1;
                    cnt_r     <= {DIV_W{1'b0}};
                    if (mdc.Run && !mdc_rst_s) begin
                        state_r <= ST_HIGH;
                    end else begin
                        state_r <= ST_PARK;
                    end
                end
                ST_HIGH: begin
                    if (!mdc.Run || mdc_rst_s) begin
                        state_r <= ST_PARK;
                        cnt_r   <= {DIV_W{1'b0}};
                    end else if (last_s) begin
                        state_r    <= ST_LOW;
                        cnt_r      <= {DIV_W{1'b0}};
                        mdc_clk_r  <= 1'b0;
                        mdc_fall_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                ST_LOW: begin
                    // LOW always runs to completion so the low pulse is never truncated.
                    if (last_s) begin
                        cnt_r      <= {DIV_W{1'b0}};
                        mdc_clk_r  <= 1'b1;
                        mdc_rise_r <= 1'b1;
                        if (mdc.Run && !mdc_rst_s) begin
                            state_r <= ST_HIGH;
                        end else begin
                            state_r <= ST_PARK;
                        end
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_PARK;
                    cnt_r     <= {DIV_W{1'b0}};
                    mdc_clk_r <= 1'b1;
                end
            endcase
        end
    end

    assign mdc.MDC_Clk  = mdc_clk_r;
    assign mdc.MDC_Rise = mdc_rise_r;
    assign mdc.MDC_Fall = mdc_fall_r;
    assign mdc.MDC_Rst  = mdc_rst_s;
endmodule

// File: tb/tb_mdc_clk_gen.sv
// Self-checking bench for mdc_clk_gen: directed timing sequences, a stop
// vector table and a randomized run against an event-scheduling model.
module tb_mdc_clk_gen;
    localparam int N = 50;

    localparam int M_PARK = 0;
    localparam int M_HIGH = 1;
    localparam int M_LOW  = 2;

    logic Clk = 1'b0;
    logic Rst;

    mdc_clk_gen_if #(.DIV_W(8)) mdc_if ();

    mdc_clk_gen #(
        .DIV_W       (8),
        .DIV_DEFAULT (N),
        .RST_STAGES  (3)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .mdc (mdc_if.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit in_low;      // drop Run during LOW (1) or during HIGH (0)
        int offset;      // edges after the phase starts before Run drops
        int exp_delay;   // edges from drop to MDC_Rise (LOW case only)
        int exp_strobes; // strobes expected once parked
    } stop_vec_t;

    stop_vec_t vecs [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_strobe(input bit want_rise, input int limit, output int edges);
        bit hit;
        hit   = 1'b0;
        edges = 0;
        while (!hit && edges < limit) begin
            step();
            edges++;
            hit = want_rise ? mdc_if.MDC_Rise : mdc_if.MDC_Fall;
        end
        if (!hit) edges = -1;
    endtask

    initial begin
        int e;
        int lows, highs, rises, falls;
        bit prev;

        vecs[0] = '{1'b0, 5,  0,  0};
        vecs[1] = '{1'b1, 10, 40, 0};
        vecs[2] = '{1'b0, 50, 0,  0};
        vecs[3] = '{1'b1, 1,  49, 0};
        vecs[4] = '{1'b1, 49, 1,  0};

        Rst             = 1'b0;
        mdc_if.Run      = 1'b0;
        mdc_if.Div_Half = 8'd0;
        mdc_if.Div_Load = 1'b0;
        #1 Rst = 1'b1;
        #2;
        chk("rst_clk",  mdc_if.MDC_Clk,  1);
        chk("rst_rise", mdc_if.MDC_Rise, 0);
        chk("rst_fall", mdc_if.MDC_Fall, 0);
        chk("rst_mrst", mdc_if.MDC_Rst,  1);
        chk("rst_pend", mdc_if.Div_Pend, 0);

        // Default divisor: reset release with Run held high
        mdc_if.Run = 1'b1;
        step();
        step();
        Rst = 1'b0;
        step(); chk("mrst_edge1", mdc_if.MDC_Rst, 1);
        step(); chk("mrst_edge2", mdc_if.MDC_Rst, 1);
        step(); chk("mrst_edge3", mdc_if.MDC_Rst, 0);
        wait_strobe(1'b0, N + 5, e);
        chk("start_latency", e, N + 1);
        lows = 1; highs = 0; rises = 0; falls = 1;
        for (int i = 1; i < 2 * N; i++) begin
            step();
            if (mdc_if.MDC_Clk) highs++; else lows++;
            if (mdc_if.MDC_Rise) rises++;
            if (mdc_if.MDC_Fall) falls++;
        end
        chk("period_low",   lows,  N);
        chk("period_high",  highs, N);
        chk("period_rises", rises, 1);
        chk("period_falls", falls, 1);
        step();
        chk("period_end_fall", mdc_if.MDC_Fall, 1);

        mdc_if.Run = 1'b0;
        wait_strobe(1'b1, 2 * N, e);
        chk("park_rise", e, N);
        repeat (3) step();
        chk("parked_clk", mdc_if.MDC_Clk, 1);

        // Stop/restart table
        for (int v = 0; v < 5; v++) begin
            mdc_if.Run = 1'b1;
            if (vecs[v].in_low) begin
                wait_strobe(1'b0, N + 5, e);
                chk("vec_restart_latency", e, N + 1);
                repeat (vecs[v].offset) step();
                mdc_if.Run = 1'b0;
                wait_strobe(1'b1, N + 5, e);
                chk("vec_low_completion", e, vecs[v].exp_delay);
            end else begin
                repeat (vecs[v].offset) step();
                mdc_if.Run = 1'b0;
            end
            lows = 0; rises = 0; falls = 0;
            for (int i = 0; i < 2 * N + 4; i++) begin
                step();
                if (!mdc_if.MDC_Clk) lows++;
                if (mdc_if.MDC_Rise) rises++;
                if (mdc_if.MDC_Fall) falls++;
            end
            chk("vec_park_lows",    lows,          0);
            chk("vec_park_strobes", rises + falls, vecs[v].exp_strobes);
        end

        // Reset in the middle of LOW
        mdc_if.Run = 1'b1;
        wait_strobe(1'b0, N + 5, e);
        chk("d_start", e, N + 1);
        repeat (5) step();
`ifdef MDC_DIV_RUNTIME_EN
        mdc_if.Div_Half = 8'd4;
        mdc_if.Div_Load = 1'b1;
        step();
        mdc_if.Div_Load = 1'b0;
        chk("d_pend_before_rst", mdc_if.Div_Pend, 1);
`endif
        chk("d_low_before_rst", mdc_if.MDC_Clk, 0);
        #2 Rst = 1'b1;
        #1;
        chk("d_rst_clk",  mdc_if.MDC_Clk,  1);
        chk("d_rst_rise", mdc_if.MDC_Rise, 0);
        chk("d_rst_fall", mdc_if.MDC_Fall, 0);
        chk("d_rst_mrst", mdc_if.MDC_Rst,  1);
        chk("d_rst_pend", mdc_if.Div_Pend, 0);
        step();
        step();
        Rst = 1'b0;
        repeat (2) step();
        chk("d_mrst_held", mdc_if.MDC_Rst, 1);
        step();
        chk("d_mrst_free", mdc_if.MDC_Rst, 0);
        wait_strobe(1'b0, N + 5, e);
        chk("d_restart_high", e, N + 1);
        wait_strobe(1'b1, N + 5, e);
        chk("d_restart_low", e, N);

`ifdef MDC_DIV_RUNTIME_EN
        // Runtime divisor load mid-LOW
        wait_strobe(1'b0, N + 5, e);
        chk("rt_fall", e, N);
        repeat (10) step();
        mdc_if.Div_Half = 8'd4;
        mdc_if.Div_Load = 1'b1;
        step();
        mdc_if.Div_Load = 1'b0;
        chk("rt_pend_set", mdc_if.Div_Pend, 1);
        wait_strobe(1'b1, N + 5, e);
        chk("rt_old_low_rest", e, N - 11);
        chk("rt_pend_clear", mdc_if.Div_Pend, 0);
        wait_strobe(1'b0, N + 5, e);
        chk("rt_high4", e, 4);
        wait_strobe(1'b1, N + 5, e);
        chk("rt_low4", e, 4);

        // Load in the same cycle as a LOW->HIGH boundary
        repeat (7) step();
        mdc_if.Div_Half = 8'd6;
        mdc_if.Div_Load = 1'b1;
        step();
        mdc_if.Div_Load = 1'b0;
        chk("bnd_rise", mdc_if.MDC_Rise, 1);
        chk("bnd_pend", mdc_if.Div_Pend, 1);
        wait_strobe(1'b0, N + 5, e);
        chk("bnd_old_high", e, 4);
        wait_strobe(1'b1, N + 5, e);
        chk("bnd_old_low", e, 4);
        chk("bnd_pend_clear", mdc_if.Div_Pend, 0);
        wait_strobe(1'b0, N + 5, e);
        chk("bnd_new_high", e, 6);

        // Divisor zero clamps to one
        mdc_if.Div_Half = 8'd0;
        mdc_if.Div_Load = 1'b1;
        step();
        mdc_if.Div_Load = 1'b0;
        wait_strobe(1'b1, N + 5, e);
        chk("z_apply", e, 5);
        prev = mdc_if.MDC_Clk;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("z_toggle", int'(mdc_if.MDC_Clk != prev), 1);
            chk("z_rise",   mdc_if.MDC_Rise, int'(mdc_if.MDC_Clk));
            chk("z_fall",   mdc_if.MDC_Fall, int'(!mdc_if.MDC_Clk));
            prev = mdc_if.MDC_Clk;
        end
`endif

        // Randomized Run (and loads) against an event-scheduling model
        mdc_if.Run      = 1'b0;
        mdc_if.Div_Load = 1'b0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        repeat (3) step();
        chk("rnd_mrst", mdc_if.MDC_Rst, 0);
        begin
            int  t, m_mode, m_n, m_pv, fall_at, rise_at;
            bit  m_pend, m_clk, m_rise, m_fall, bnd, go_high, run, ld;
            int  ldv;
            t = 0; m_mode = M_PARK; m_n = N; m_pv = 0; m_pend = 1'b0;
            m_clk = 1'b1; fall_at = 0; rise_at = 0; run = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 39) == 0) run = ~run;
                ld  = 1'b0;
                ldv = 0;
`ifdef MDC_DIV_RUNTIME_EN
                if ($urandom_range(0, 29) == 0) begin
                    ld  = 1'b1;
                    ldv = int'($urandom_range(0, 6));
                end
`endif
                mdc_if.Run      = run;
                mdc_if.Div_Load = ld;
                mdc_if.Div_Half = 8'(ldv);
                @(posedge Clk);
                t++;
                m_rise = 1'b0; m_fall = 1'b0; bnd = 1'b0; go_high = 1'b0;
                case (m_mode)
                    M_PARK: begin
                        if (run) begin
                            m_mode  = M_HIGH;
                            fall_at = t + m_n;
                        end
                    end
                    M_HIGH: begin
                        if (!run) begin
                            m_mode = M_PARK;
                            bnd    = 1'b1;
                        end else if (t == fall_at) begin
                            m_mode  = M_LOW;
                            m_clk   = 1'b0;
                            m_fall  = 1'b1;
                            rise_at = t + m_n;
                        end
                    end
                    default: begin
                        if (t == rise_at) begin
                            m_clk  = 1'b1;
                            m_rise = 1'b1;
                            bnd    = 1'b1;
                            if (run) go_high = 1'b1;
                            else     m_mode  = M_PARK;
                        end
                    end
                endcase
                if (bnd && m_pend) begin
                    m_n    = (m_pv == 0) ? 1 : m_pv;
                    m_pend = 1'b0;
                end
                if (ld) begin
                    m_pend = 1'b1;
                    m_pv   = ldv;
                end
                if (go_high) begin
                    m_mode  = M_HIGH;
                    fall_at = t + m_n;
                end
                #1;
                chk("rnd_clk",  mdc_if.MDC_Clk,  int'(m_clk));
                chk("rnd_rise", mdc_if.MDC_Rise, int'(m_rise));
                chk("rnd_fall", mdc_if.MDC_Fall, int'(m_fall));
                chk("rnd_pend", mdc_if.Div_Pend, int'(m_pend));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdc_clk_gen.md
# mdc_clk_gen

Parametrised MDC clock and reset generator for the management interface. It divides the system clock `Clk` by a runtime-programmable even ratio and drives the MDC pin from a register. It also produces single-cycle rise/fall strobes, so MDIO shift logic can stay in the `Clk` domain on clock enables. It supports a clean start/stop that parks MDC high, and generates a synchronised management reset.

## Interface
- `DIV_W`, 8: width of the half-period divisor and the internal counter.
- `DIV_DEFAULT`, 50: half-period in `Clk` cycles after reset (100 MHz → 1 MHz MDC). Must be ≥1 and < 2^DIV_W.
- `RST_STAGES`, 3: reset synchroniser depth, ≥2.
- `Clk`  in  1  system clock; the only clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `Run`  in  1  level; 1 = MDC toggling requested, 0 = park MDC high.
- `Div_Half`  in  DIV_W  new half-period value.
- `Div_Load`  in  1  one-cycle pulse; captures `Div_Half` as the pending divisor.
- `MDC_Clk`  out  1  registered MDC output; reset value 1.
- `MDC_Rise`  out  1  high for the first `Clk` cycle in which `MDC_Clk` is 1 after a 0→1 transition; reset value 0.
- `MDC_Fall`  out  1  same rule for 1→0 transitions; reset value 0.
- `MDC_Rst`  out  1  active-high management reset; reset value 1.
- `Div_Pend`  out  1  a loaded divisor has not yet been applied; reset value 0.

## Operation
- **States:** PARK, HIGH, LOW. Reset enters PARK with counter 0 and active divisor = `DIV_DEFAULT`.
- **Reset synchroniser:**
  - `Rst` asserts `MDC_Rst` asynchronously.
  - `MDC_Rst` deasserts synchronously on the `RST_STAGES`-th `Clk` rising edge after `Rst` is released.
  - While `MDC_Rst` = 1 the FSM is held in PARK.
- **Divisor clamp:** N = active divisor; a value of 0 is treated as 1.
  - Each half period lasts exactly N cycles; the MDC period is 2N.
- **PARK:** `MDC_Clk` = 1, counter = 0.
  - If `Run` = 1 and `MDC_Rst` = 0, go to HIGH.
  - Entry into PARK applies any pending divisor.
- **HIGH:** counter increments each cycle. When counter = N−1:
  - if `Run` = 1: clear the counter, drive `MDC_Clk` low, pulse `MDC_Fall`, go to LOW;
  - if `Run` = 0: go to PARK.
- **HIGH exit on stop:** if `Run` drops mid-HIGH, the block goes to PARK immediately (MDC already high, no glitch).
- **LOW:** always completes N cycles regardless of `Run`. At the end: drive `MDC_Clk` high, pulse `MDC_Rise`, then:
  - `Run` = 1 → HIGH;
  - `Run` = 0 → PARK.
- **Minimum pulse widths:** no high or low pulse is ever shorter than min(old N, new N) cycles.
- **Divisor update:**
  - `Div_Load` writes the pending register and sets `Div_Pend`; a later load overwrites an earlier one.
  - The pending value becomes active only at a LOW→HIGH boundary or on PARK entry, and `Div_Pend` clears then.
  - A load in the same cycle as a boundary is applied at the *next* boundary.
- **Reset mid-operation:** all outputs return to reset values asynchronously and the pending divisor is discarded.

## Timing
- `MDC_Clk`, `MDC_Rise` and `MDC_Fall` are registered; the strobes coincide with the first cycle of the new level.
- Start latency: `Run` sampled 1 in PARK → first `MDC_Fall` N+1 cycles later.
- After `Rst` release with `Run` = 1: `MDC_Rst` falls at edge `RST_STAGES`; the first `MDC_Fall` follows N+1 cycles later.
- Counter arithmetic is DIV_W-bit unsigned with no wrap; it never exceeds N−1.

## Configuration
- **`MDC_DIV_RUNTIME_EN` defined:** runtime divisor loading and `Div_Pend` behave as specified above.
- **Not defined:**
  - `Div_Half` and `Div_Load` are ignored;
  - the divisor is fixed at `DIV_DEFAULT`;
  - `Div_Pend` is tied to 0;
  - no pending register is synthesised.

## Structure
- Package `mdc_pkg` holds:
  - the state encoding (PARK, HIGH, LOW);
  - the default constants (DIV_W = 8, DIV_DEFAULT = 50, RST_STAGES = 3);
  - a divisor-clamp helper function.
- Sub-module `mdc_rst_sync`: parametrised asynchronous-assert / synchronous-deassert chain (`RST_STAGES`), producing `MDC_Rst`.

## Test plan
- **Default divisor:** `Rst` pulse, `Run` = 1, default build → `MDC_Rst` falls after 3 edges; `MDC_Clk` period 100 cycles, 50 high / 50 low; one `MDC_Fall` and one `MDC_Rise` per period.
- **Runtime divisor:** load `Div_Half` = 4 mid-LOW with `MDC_DIV_RUNTIME_EN` → `Div_Pend` = 1 until the next rise, then a period of 8; no pulse shorter than 4 cycles.
- **Divisor zero:** `Div_Half` = 0 → clamped to 1; `MDC_Clk` toggles every cycle and strobes alternate every cycle.
- **Stop mid-LOW:** drop `Run` 10 cycles into LOW (N = 50) → LOW completes 50 cycles, `MDC_Rise` fires, MDC parks high with no further `MDC_Fall`.
- **Stop mid-HIGH and restart:** drop `Run` mid-HIGH → immediate PARK, MDC stays high. Reassert `Run` → next `MDC_Fall` exactly N+1 cycles later.
- **Reset mid-operation:** assert `Rst` during LOW with a load pending → `MDC_Clk` = 1, strobes = 0, `MDC_Rst` = 1, `Div_Pend` = 0 without waiting for a clock edge. The divisor returns to 50.
